// File: rtl/decrementor_counter_4.sv
// Loadable down-counter/delay timer: q-1 from a NAND-level half-subtractor ripple chain,
// single-step decrement with borrow, and a run-to-zero sequence with busy/done. Option macro: DCNT_AUTORELOAD_EN.
//
// state | meaning
// IDLE  | accepts load > start > dec
// COUNT | decrementing toward zero, busy=1
// DONE  | one-cycle done pulse, then IDLE
module decrementor_counter_4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             start,
   input  logic             dec,
   input  logic             hold,
   output logic [WIDTH-1:0] q,
   output logic             borrow,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] q_r, q_n;
   logic [WIDTH-1:0] q_m1;
   logic [WIDTH:0]   bchain;
   logic             busy_r, busy_n;
   logic             done_r, done_n;
   logic             borrow_r, borrow_n;
   logic             last_step;

   // Borrow-in of 1 at bit 0 makes the chain compute q-1; the final borrow-out flags a 0 -> all-ones wrap.
   assign bchain[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_hsub
         logic n_ab, n_a, n_b, a_inv, b_and;
         nand u_x1 (n_ab, q_r[i], bchain[i]);
         nand u_x2 (n_a, q_r[i], n_ab);
         nand u_x3 (n_b, bchain[i], n_ab);
         nand u_x4 (q_m1[i], n_a, n_b);
         nand u_b1 (a_inv, q_r[i], q_r[i]);
         nand u_b2 (b_and, a_inv, bchain[i]);
         nand u_b3 (bchain[i+1], b_and, b_and);
      end
   endgenerate

   assign zero      = (q_r == '0);
   assign last_step = (q_m1 == '0);

`ifdef DCNT_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_r, reload_n;
`endif

   always_comb begin
      state_n  = state;
      q_n      = q_r;
      borrow_n = 1'b0;
      done_n   = 1'b0;
`ifdef DCNT_AUTORELOAD_EN
      reload_n = reload_r;
`endif
      case (state)
         IDLE: begin
            if (load) begin
               q_n = din;
`ifdef DCNT_AUTORELOAD_EN
               reload_n = din;
`endif
            end else if (start) begin
               state_n = zero ? DONE : COUNT;
            end else if (dec) begin
               q_n      = q_m1;
               borrow_n = bchain[WIDTH];
            end
         end
         COUNT: begin
`ifdef DCNT_AUTORELOAD_EN
            if (start) begin
               state_n = IDLE;
            end else if (!hold) begin
               if (last_step && reload_r != '0) begin
                  q_n    = reload_r;
                  done_n = 1'b1;
               end else begin
                  q_n = q_m1;
                  if (last_step) state_n = DONE;
               end
            end
`else
            if (!hold) begin
               q_n = q_m1;
               if (last_step) state_n = DONE;
            end
`endif
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == COUNT);
      done_n = done_n | (state_n == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         q_r      <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         borrow_r <= 1'b0;
`ifdef DCNT_AUTORELOAD_EN
         reload_r <= '0;
`endif
      end else begin
         state    <= state_n;
         q_r      <= q_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
         borrow_r <= borrow_n;
`ifdef DCNT_AUTORELOAD_EN
         reload_r <= reload_n;
`endif
      end
   end

   assign q      = q_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign borrow = borrow_r;

endmodule
